prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of processor_top.
- Accepts a framed byte stream, packs bytes into 16-bit instruction/data words and writes them into the processor's unified memory.
- Holds the processor in reset until the whole image has loaded and its checksum verifies, then releases it.
- Replaces hierarchical memory preloading: the bench drives bytes, the CPU executes what was loaded.

Parameters:
- ADDR_W, 8: memory address width; memory depth is 2^ADDR_W words.
- BASE_ADDR, 0: address written with the first word.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy=1.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data, {high byte, low byte}.
- cpu_reset  out  1  active-high reset to processor_top.reset.
- busy  out  1  load in progress.
- done  out  1  image loaded and verified; held.
- error  out  1  load failed; held.

Behaviour:
- Reset (reset=0 at a clk edge) values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, state=IDLE. Reset has priority over every event, including in the middle of a load; partial memory contents are left as written.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N words, each sent as a high byte then a low byte.
  - CHK: one byte equal to the XOR of every preceding frame byte, length bytes included.
- Byte acceptance: a byte is accepted on a clk edge where in_valid=1 and in_ready=1. in_ready is a registered function of state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK; 0 otherwise.
- State machine:
  - IDLE / DONE / ERROR --start--> LEN_HI. On entry: busy=1, done=0, error=0, cpu_reset=1, checksum accumulator=0, word index=0.
  - LEN_HI --accept--> LEN_LO.
  - LEN_LO --accept-->
    - ERROR if N > 2^ADDR_W - BASE_ADDR;
    - else CHK if N=0;
    - else DATA_HI.
  - DATA_HI --accept--> DATA_LO; high byte latched.
  - DATA_LO --accept--> WRITE.
  - WRITE lasts exactly one cycle, with mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata={hi,lo}. Index then increments. Next state is CHK if index+1=N, else DATA_HI.
  - CHK --accept-->
    - DONE if in_data equals the accumulator: busy=0, done=1, cpu_reset=0 from the next cycle on;
    - otherwise ERROR: busy=0, error=1, cpu_reset stays 1.
- Latency:
  - mem_we asserts in the cycle after the low byte is accepted.
  - cpu_reset falls in the cycle after the CHK byte is accepted.
  - Minimum frame time is 2N+3 accepted bytes plus N WRITE cycles.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values otherwise.
- Address range: the length check ensures no write ever exceeds 2^ADDR_W-1, so the address never wraps.
- Idle input: in_valid=0 stalls in any receive state indefinitely with no timeout. Bytes presented while in_ready=0 are not consumed.
- start pulses while busy=1 are ignored.
- DONE and ERROR hold until the next start or reset.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 00 04 0D 80 23 80 90 03 B2 02 09 with in_valid held 1.
  - Required: writes mem[0]=0D80, mem[1]=2380, mem[2]=9003, mem[3]=B202, each one cycle after its low byte; then done=1 and cpu_reset=0. With the processor attached and x2=5, x3=10, memory reads back x1=000F.
- Bad checksum:
  - Stimulus: the same frame with a final byte of 08.
  - Required: all four writes occur, then error=1, done=0, cpu_reset stays 1, busy=0.
- Zero length:
  - Stimulus: bytes 00 00 00.
  - Required: no mem_we pulse; done=1 after the third byte is accepted.
- Oversize length (ADDR_W=8, BASE_ADDR=0):
  - Stimulus: bytes 01 01.
  - Required: error=1 in the cycle after LEN_LO is accepted; no writes; later bytes are not accepted (in_ready=0).
- Stalls and stray start:
  - Stimulus: the nominal frame with in_valid toggling 1/0 every cycle, plus a start pulse sent mid-frame.
  - Required: results identical to the nominal load; the mid-frame start has no effect.
- Reset mid-load:
  - Stimulus: assert reset=0 after the 5th byte, then re-run the nominal load.
  - Required: all outputs return to their reset values, then the second load completes with done=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader placed in front of processor_top.
//
// Receives a framed byte stream, packs byte pairs into 16-bit words, writes
// them into the processor's unified memory and holds the processor in reset
// until the whole image has arrived with a matching checksum.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), N x {HI, LO}, CHK where
// CHK is the XOR of every preceding frame byte (length bytes included).
//
// Handshake: a byte is consumed on a rising clk edge where in_valid=1 and
// in_ready=1. in_ready is registered and depends only on the FSM state, so
// it never combinationally follows in_valid; bytes presented while
// in_ready=0 stay with the sender.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   one-cycle pulse that begins a load (ignored while busy)
//   in_valid   in   in_data holds a byte
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  one-cycle memory write strobe
//   mem_addr   out  write address (ADDR_W bits)
//   mem_wdata  out  write data {high byte, low byte}
//   cpu_reset  out  active-high reset for processor_top
//   busy       out  load in progress
//   done       out  image loaded and verified (held)
//   error      out  load failed (held)
//   dbg_state  out  current FSM state encoding, for observation only
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_CHK     = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_e;

  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q;
  logic [15:0]         len_q;
  logic [7:0]          acc_q;
  logic [16:0]         idx_q;
  logic [7:0]          hi_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;

  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                idle_like;
  logic [15:0]         len_now;

  assign accept    = in_valid && in_ready_q;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign len_now   = {len_hi_q, in_data};

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_now} > MAX_WORDS) state_d = S_ERROR;
          else if (len_now == 16'd0)       state_d = S_CHK;
          else                             state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) state_d = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        // idx_q still holds the index of the word being written here.
        if ((idx_q + 17'd1) == {1'b0, len_q}) state_d = S_CHK;
        else                                  state_d = S_DATA_HI;
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == acc_q) state_d = S_DONE;
          else                  state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode: computed from the next state and registered below, so
  // each output is a clean flop that tracks the state one-for-one.
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    cpu_reset_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_we_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
      end
      S_ERROR: begin
        error_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: length, checksum, word index and the write port registers.
  // The address/data pair is captured with the low byte so it is already
  // stable during the WRITE cycle, and it simply holds afterwards.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      acc_q    <= 8'd0;
      idx_q    <= 17'd0;
      hi_q     <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= 16'd0;
    end else begin
      if (idle_like && start) begin
        acc_q <= 8'd0;
        idx_q <= 17'd0;
      end
      if (accept) begin
        case (state_q)
          S_LEN_HI: begin
            len_hi_q <= in_data;
            acc_q    <= acc_q ^ in_data;
          end
          S_LEN_LO: begin
            len_q <= len_now;
            acc_q <= acc_q ^ in_data;
          end
          S_DATA_HI: begin
            hi_q  <= in_data;
            acc_q <= acc_q ^ in_data;
          end
          S_DATA_LO: begin
            acc_q   <= acc_q ^ in_data;
            addr_q  <= ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
            wdata_q <= {hi_q, in_data};
          end
          default: begin
          end
        endcase
      end
      if (state_q == S_WRITE) begin
        idx_q <= idx_q + 17'd1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [23:0] wr_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc[$];
  logic [7:0]  frame_q[$];

  // Expected nominal writes {addr, data}, worked out by hand from the frame.
  logic [23:0] nom_exp[4] = '{24'h000D80, 24'h012380, 24'h029003, 24'h03B202};

  prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: byte %h in_ready=%b required 1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cyc.push_back(cyc);
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_frame(input bit gap, input int stray_idx);
    acc_cyc.delete();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], gap);
      if (i == stray_idx) pulse_start();
    end
    in_valid = 1'b0;
  endtask

  task automatic set_nominal(input logic [7:0] last);
    frame_q = '{8'h00, 8'h04, 8'h0D, 8'h80, 8'h23, 8'h80, 8'h90, 8'h03, 8'hB2, 8'h02, last};
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0)     begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (dbg_state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    clear_log();
    set_nominal(8'h09);
    pulse_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL nom_start: busy=%b in_ready=%b want 1 1", busy, in_ready); end
    send_frame(1'b0, -1);
    @(negedge clk);
    checks++; if (wr_q.size() !== 4) begin fails++; $display("FAIL nom_wr_count: got %0d want 4", wr_q.size()); end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      checks++; if (wr_q[k] !== nom_exp[k]) begin fails++; $display("FAIL nom_wr%0d: got %h want %h", k, wr_q[k], nom_exp[k]); end
      checks++; if (wr_cyc_q[k] !== acc_cyc[3+2*k]) begin fails++; $display("FAIL nom_wr%0d_cycle: got %0d want %0d", k, wr_cyc_q[k], acc_cyc[3+2*k]); end
    end
    checks++; if (done !== 1'b1)      begin fails++; $display("FAIL nom_done: got %b want 1", done); end
    checks++; if (cpu_reset !== 1'b0) begin fails++; $display("FAIL nom_cpu_reset: got %b want 0", cpu_reset); end
    checks++; if (busy !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL nom_idle_flags: busy=%b error=%b in_ready=%b want 0 0 0", busy, error, in_ready); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    set_nominal(8'h08);
    pulse_start();
    @(negedge clk);
    checks++; if ({done, busy, cpu_reset} !== 3'b011) begin fails++; $display("FAIL bad_restart: done,busy,cpu_reset=%b want 011", {done, busy, cpu_reset}); end
    @(posedge clk); #1;
    send_frame(1'b0, -1);
    @(negedge clk);
    checks++; if (wr_q.size() !== 4) begin fails++; $display("FAIL bad_wr_count: got %0d want 4", wr_q.size()); end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      checks++; if (wr_q[k] !== nom_exp[k]) begin fails++; $display("FAIL bad_wr%0d: got %h want %h", k, wr_q[k], nom_exp[k]); end
    end
    checks++; if ({error, done, cpu_reset, busy} !== 4'b1010) begin fails++; $display("FAIL bad_flags: error,done,cpu_reset,busy=%b want 1010", {error, done, cpu_reset, busy}); end
  endtask

  task automatic test_zero_len();
    clear_log();
    frame_q = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(1'b0, -1);
    @(negedge clk);
    checks++; if (wr_q.size() !== 0) begin fails++; $display("FAIL zero_wr_count: got %0d want 0", wr_q.size()); end
    checks++; if ({done, cpu_reset, error} !== 3'b100) begin fails++; $display("FAIL zero_flags: done,cpu_reset,error=%b want 100", {done, cpu_reset, error}); end
  endtask

  task automatic test_oversize();
    bit saw_ready;
    clear_log();
    frame_q = '{8'h01, 8'h01};
    pulse_start();
    send_frame(1'b0, -1);
    @(negedge clk);
    checks++; if ({error, busy, done} !== 3'b100) begin fails++; $display("FAIL over_flags: error,busy,done=%b want 100", {error, busy, done}); end
    saw_ready = 1'b0;
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) saw_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (saw_ready !== 1'b0) begin fails++; $display("FAIL over_in_ready: got 1 want 0"); end
    checks++; if (error !== 1'b1 || dbg_state !== 4'd8) begin fails++; $display("FAIL over_hold: error=%b state=%0d want 1 8", error, dbg_state); end
    checks++; if (wr_q.size() !== 0) begin fails++; $display("FAIL over_wr_count: got %0d want 0", wr_q.size()); end
  endtask

  task automatic test_stalls();
    clear_log();
    set_nominal(8'h09);
    pulse_start();
    send_frame(1'b1, 4);
    @(negedge clk);
    checks++; if (wr_q.size() !== 4) begin fails++; $display("FAIL stall_wr_count: got %0d want 4", wr_q.size()); end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      checks++; if (wr_q[k] !== nom_exp[k]) begin fails++; $display("FAIL stall_wr%0d: got %h want %h", k, wr_q[k], nom_exp[k]); end
      checks++; if (wr_cyc_q[k] !== acc_cyc[3+2*k]) begin fails++; $display("FAIL stall_wr%0d_cycle: got %0d want %0d", k, wr_cyc_q[k], acc_cyc[3+2*k]); end
    end
    checks++; if ({done, cpu_reset, error, busy} !== 4'b1000) begin fails++; $display("FAIL stall_flags: done,cpu_reset,error,busy=%b want 1000", {done, cpu_reset, error, busy}); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    set_nominal(8'h09);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error} !== {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset_outputs: got rdy=%b we=%b addr=%h wd=%h cpu_rst=%b busy=%b done=%b err=%b want 0 0 00 0000 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    clear_log();
    pulse_start();
    send_frame(1'b0, -1);
    @(negedge clk);
    checks++; if (wr_q.size() !== 4) begin fails++; $display("FAIL mid_wr_count: got %0d want 4", wr_q.size()); end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      checks++; if (wr_q[k] !== nom_exp[k]) begin fails++; $display("FAIL mid_wr%0d: got %h want %h", k, wr_q[k], nom_exp[k]); end
    end
    checks++; if ({done, cpu_reset} !== 2'b10) begin fails++; $display("FAIL mid_done: done,cpu_reset=%b want 10", {done, cpu_reset}); end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_zero_len();
    test_oversize();
    test_stalls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
